// File: rtl/smart_cfg_ctrl.sv
// Multi-zone configuration controller: authenticates a session against the stored key,
// then commits one record into a selected zone register, with lockout and idle timeout.
module smart_cfg_ctrl #(
    parameter int unsigned CFG_W       = 35,
    parameter int unsigned ZONES       = 4,
    parameter int unsigned ZSEL_W      = 2,
    parameter int unsigned KEY_W       = 2,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    request,
    input  logic                    confirm,
    input  logic [KEY_W-1:0]        password,
    input  logic [ZSEL_W-1:0]       zone,
    input  logic [CFG_W-1:0]        configin,
    output logic [ZONES*CFG_W-1:0]  cfg_out,
    output logic [ZONES-1:0]        cfg_valid,
    output logic                    write_en,
    output logic [ZSEL_W-1:0]       wr_zone,
    output logic                    err,
    output logic                    locked,
    output logic [2:0]              dbg_state
);

    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [ZSEL_W:0]   ZONE_LIM  = (ZSEL_W + 1)'(ZONES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AUTH  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_LOCK  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [CFG_W-1:0]    rec_q, rec_d;
    logic [ZSEL_W-1:0]   wr_zone_q, wr_zone_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic                locked_q;
    logic                commit_c;
    logic [CFG_W-1:0]    cfg_q [ZONES];
    logic [ZONES-1:0]    valid_q;

    // Next-state, counters and pulse requests
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        fail_d    = fail_q;
        lock_d    = lock_q;
        key_d     = key_q;
        rec_d     = rec_q;
        wr_zone_d = wr_zone_q;
        we_d      = 1'b0;
        err_d     = 1'b0;
        commit_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (request) begin
                    state_d = S_AUTH;
                    tmr_d   = '0;
                end
            end
            S_AUTH: begin
                if (confirm) begin
                    if (password == key_q) begin
                        state_d = S_LOAD;
                        fail_d  = '0;
                        tmr_d   = '0;
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_q >= FAIL_LAST) begin
                            state_d = S_LOCK;
                            lock_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (tmr_q >= TMR_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_LOAD: begin
                if (confirm) begin
                    if ({1'b0, zone} < ZONE_LIM) begin
                        state_d   = S_WRITE;
                        rec_d     = configin;
                        wr_zone_d = zone;
                        we_d      = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tmr_q >= TMR_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WRITE: begin
                // Record lands in its zone as this cycle ends; key follows the record's top bits
                commit_c = 1'b1;
                key_d    = rec_q[CFG_W-1 -: KEY_W];
                state_d  = S_IDLE;
            end
            S_LOCK: begin
                if (lock_q >= LOCK_LAST) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, zone storage and registered outputs
    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            fail_q    <= '0;
            lock_q    <= '0;
            key_q     <= '0;
            rec_q     <= '0;
            wr_zone_q <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            valid_q   <= '0;
            for (int unsigned i = 0; i < ZONES; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            fail_q    <= fail_d;
            lock_q    <= lock_d;
            key_q     <= key_d;
            rec_q     <= rec_d;
            wr_zone_q <= wr_zone_d;
            we_q      <= we_d;
            err_q     <= err_d;
            locked_q  <= (state_d == S_LOCK);
            for (int unsigned i = 0; i < ZONES; i++) begin
                if (commit_c && (wr_zone_q == ZSEL_W'(i))) begin
                    cfg_q[i]   <= rec_q;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < ZONES; g++) begin : g_zone
        assign cfg_out[g*CFG_W +: CFG_W] = cfg_q[g];
    end

    assign cfg_valid = valid_q;
    assign write_en  = we_q;
    assign wr_zone   = wr_zone_q;
    assign err       = err_q;
    assign locked    = locked_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_smart_cfg_ctrl.sv
// Bench for smart_cfg_ctrl: a 4-zone and a 3-zone build share one stimulus stream and are
// compared every cycle against a session-level model, plus literal pins on key moments.
module tb_smart_cfg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst, request, confirm;
    logic [1:0]  password, zone;
    logic [34:0] configin;

    logic [139:0] cfg_out0;
    logic [3:0]   cfg_valid0;
    logic         we0, err0, locked0;
    logic [1:0]   wz0;
    logic [2:0]   dbg0;

    logic [104:0] cfg_out1;
    logic [2:0]   cfg_valid1;
    logic         we1, err1, locked1;
    logic [1:0]   wz1;
    logic [2:0]   dbg1;

    smart_cfg_ctrl dut0 (
        .clk(clk), .arst(arst), .request(request), .confirm(confirm),
        .password(password), .zone(zone), .configin(configin),
        .cfg_out(cfg_out0), .cfg_valid(cfg_valid0), .write_en(we0), .wr_zone(wz0),
        .err(err0), .locked(locked0), .dbg_state(dbg0)
    );

    smart_cfg_ctrl #(.ZONES(3), .ZSEL_W(2)) dut1 (
        .clk(clk), .arst(arst), .request(request), .confirm(confirm),
        .password(password), .zone(zone), .configin(configin),
        .cfg_out(cfg_out1), .cfg_valid(cfg_valid1), .write_en(we1), .wr_zone(wz1),
        .err(err1), .locked(locked1), .dbg_state(dbg1)
    );

    // Model: phase 0 idle, 1 awaiting password, 2 awaiting record, 3 committing, 4 locked out
    int          m_ph   [2];
    int          m_idle [2];
    int          m_fail [2];
    int          m_lk   [2];
    int          m_key  [2];
    int          m_wz   [2];
    logic [34:0] m_rec  [2];
    logic [34:0] m_cfg  [2][4];
    logic        m_val  [2][4];
    logic        m_we   [2];
    logic        m_err  [2];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int nz);
        m_we[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (!arst) begin
            m_ph[k] = 0; m_idle[k] = 0; m_fail[k] = 0; m_lk[k] = 0;
            m_key[k] = 0; m_wz[k] = 0; m_rec[k] = '0;
            for (int z = 0; z < 4; z++) begin
                m_cfg[k][z] = '0;
                m_val[k][z] = 1'b0;
            end
        end else if (m_ph[k] == 0) begin
            if (request) begin m_ph[k] = 1; m_idle[k] = 0; end
        end else if (m_ph[k] == 1) begin
            if (confirm && int'(password) == m_key[k]) begin
                m_ph[k] = 2; m_fail[k] = 0; m_idle[k] = 0;
            end else if (confirm) begin
                m_err[k]  = 1'b1;
                m_fail[k] = m_fail[k] + 1;
                if (m_fail[k] == 3) begin m_ph[k] = 4; m_lk[k] = 0; end
                else m_ph[k] = 0;
            end else begin
                m_idle[k]++;
                if (m_idle[k] == 255) begin m_ph[k] = 0; m_err[k] = 1'b1; end
            end
        end else if (m_ph[k] == 2) begin
            if (confirm && int'(zone) < nz) begin
                m_ph[k] = 3; m_rec[k] = configin; m_wz[k] = int'(zone); m_we[k] = 1'b1;
            end else if (confirm) begin
                m_ph[k] = 0; m_err[k] = 1'b1;
            end else begin
                m_idle[k]++;
                if (m_idle[k] == 255) begin m_ph[k] = 0; m_err[k] = 1'b1; end
            end
        end else if (m_ph[k] == 3) begin
            m_cfg[k][m_wz[k]] = m_rec[k];
            m_val[k][m_wz[k]] = 1'b1;
            m_key[k] = int'(m_rec[k][34:33]);
            m_ph[k]  = 0;
        end else begin
            m_lk[k]++;
            if (m_lk[k] == 16) begin m_ph[k] = 0; m_fail[k] = 0; end
        end
    endtask

    task automatic cmp_dut(input int k, input int nz, input logic [2:0] dbg, input logic lk,
                           input logic we, input logic [1:0] wz, input logic er,
                           input logic [3:0] val, input logic [139:0] cfg);
        chk($sformatf("dut%0d dbg_state", k), 64'(dbg), 64'(m_ph[k]));
        chk($sformatf("dut%0d locked", k), 64'(lk), 64'(m_ph[k] == 4));
        chk($sformatf("dut%0d write_en", k), 64'(we), 64'(m_we[k]));
        chk($sformatf("dut%0d wr_zone", k), 64'(wz), 64'(m_wz[k]));
        chk($sformatf("dut%0d err", k), 64'(er), 64'(m_err[k]));
        for (int z = 0; z < nz; z++) begin
            chk($sformatf("dut%0d cfg_valid[%0d]", k, z), 64'(val[z]), 64'(m_val[k][z]));
            chk($sformatf("dut%0d cfg_out[%0d]", k, z), 64'(cfg[z*35 +: 35]), 64'(m_cfg[k][z]));
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp_dut(0, 4, dbg0, locked0, we0, wz0, err0, cfg_valid0, cfg_out0);
            cmp_dut(1, 3, dbg1, locked1, we1, wz1, err1, {1'b0, cfg_valid1}, {35'b0, cfg_out1});
        end
    end

    task automatic cyc(input logic r, input logic c, input logic [1:0] pw,
                       input logic [1:0] zn, input logic [34:0] cf, input logic a);
        arst = a; request = r; confirm = c; password = pw; zone = zn; configin = cf;
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 3);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
    endtask

    initial begin
        arst = 1'b0; request = 1'b0; confirm = 1'b0;
        password = '0; zone = '0; configin = '0;
        check_en = 1'b1;

        cyc(1'b0, 1'b0, 2'd0, 2'd0, 35'h0, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 2'd0, 35'h0, 1'b0);
        chk("reset dbg_state", 64'(dbg0), 64'd0);
        chk("reset cfg_out zero", 64'(cfg_out0 == '0), 64'd1);

        // First write: key 0, zone 2
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        chk("auth entered", 64'(dbg0), 64'd1);
        cyc(1'b0, 1'b1, 2'd0, 2'd0, 35'h0, 1'b1);
        chk("load entered", 64'(dbg0), 64'd2);
        cyc(1'b0, 1'b1, 2'd0, 2'd2, 35'h5_1234_5678, 1'b1);
        chk("write_en pulse", 64'(we0), 64'd1);
        chk("wr_zone", 64'(wz0), 64'd2);
        idle(1);
        chk("zone2 record", 64'(cfg_out0[70 +: 35]), 64'h5_1234_5678);
        chk("cfg_valid after write", 64'(cfg_valid0), 64'h4);

        // Three wrong passwords -> lockout for 16 cycles, requests ignored
        for (int t = 0; t < 3; t++) begin
            cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
            cyc(1'b0, 1'b1, 2'd1, 2'd0, 35'h0, 1'b1);
            chk("wrong pw err", 64'(err0), 64'd1);
        end
        chk("lock entered", 64'(dbg0), 64'd4);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b1, 2'd2, 2'd0, 35'h0, 1'b1);
            chk("locked held", 64'(locked0), 64'd1);
        end
        idle(1);
        chk("lock released", 64'(locked0), 64'd0);
        chk("idle after lock", 64'(dbg0), 64'd0);

        // Two wrong, one correct (key now 2), then a later wrong must not lock
        for (int t = 0; t < 2; t++) begin
            cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
            cyc(1'b0, 1'b1, 2'd3, 2'd0, 35'h0, 1'b1);
        end
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 2'd0, 35'h0, 1'b1);
        chk("key 2 accepted", 64'(dbg0), 64'd2);
        cyc(1'b0, 1'b1, 2'd0, 2'd1, 35'h4_0000_00AA, 1'b1);
        idle(1);
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd1, 2'd0, 35'h0, 1'b1);
        chk("later wrong err", 64'(err0), 64'd1);
        chk("later wrong no lock", 64'(dbg0), 64'd0);

        // AUTH timeout: 254 quiet cycles stay, the 255th aborts
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        idle(254);
        chk("auth before timeout", 64'(dbg0), 64'd1);
        idle(1);
        chk("auth timeout err", 64'(err0), 64'd1);
        chk("auth timeout idle", 64'(dbg0), 64'd0);

        // LOAD timeout
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 2'd0, 35'h0, 1'b1);
        idle(255);
        chk("load timeout err", 64'(err0), 64'd1);

        // Zone 3: valid on the 4-zone build, out of range on the 3-zone build
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 2'd3, 35'h4_DEAD_BEEF, 1'b1);
        chk("3-zone bad zone err", 64'(err1), 64'd1);
        chk("3-zone no write", 64'(we1), 64'd0);
        chk("4-zone writes zone3", 64'(we0), 64'd1);
        idle(1);
        chk("3-zone valid unchanged", 64'(cfg_valid1), 64'h6);
        chk("4-zone valid", 64'(cfg_valid0), 64'hE);

        // Reset mid-LOAD, then request+confirm together from IDLE
        cyc(1'b1, 1'b0, 2'd0, 2'd0, 35'h0, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 2'd0, 35'h0, 1'b1);
        chk("load before reset", 64'(dbg0), 64'd2);
        cyc(1'b1, 1'b1, 2'd2, 2'd1, 35'h7_FFFF_FFFF, 1'b0);
        chk("reset clears valid", 64'(cfg_valid0), 64'd0);
        chk("reset clears cfg", 64'(cfg_out0 == '0), 64'd1);
        chk("reset idle", 64'(dbg0), 64'd0);
        cyc(1'b1, 1'b1, 2'd0, 2'd0, 35'h0, 1'b1);
        chk("req+conf only auth", 64'(dbg0), 64'd1);
        chk("req+conf no err", 64'(err0), 64'd0);
        cyc(1'b0, 1'b1, 2'd0, 2'd0, 35'h0, 1'b1);
        chk("key reset to 0", 64'(dbg0), 64'd2);
        idle(2);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
